// File: rtl/change_dispenser.sv
// change_dispenser
// Pays out change one coin at a time using five denominations
// (5, 10, 25, 50 and 100 centavos). The amount is split greedily, largest
// coin first, against a per-denomination inventory. Each coin is ejected
// through a req/ack handshake. Any amount that could not be paid is
// reported at the end.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   start      begin paying `amount` (sampled in IDLE only)
//   amount     change to pay, centavos
//   refill     reload every inventory counter to INIT_COUNT (IDLE only)
//   coin_ack   payout mechanism has ejected the requested coin (level)
//   coin_req   request ejection of the coin selected by coin_sel
//   coin_sel   one-hot coin select: bit0=5 bit1=10 bit2=25 bit3=50 bit4=100
//   busy       high whenever the block is not idle
//   done       one-cycle pulse at the end of a payout
//   short      unpaid amount is nonzero (held until the next start)
//   remaining  unpaid amount (held until the next start)
//   inv_empty  per-denomination counter is zero, same bit order as coin_sel
module change_dispenser #(
   parameter int AMT_W      = 8,
   parameter int CNT_W      = 4,
   parameter int INIT_COUNT = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   input  logic             refill,
   input  logic             coin_ack,
   output logic             coin_req,
   output logic [4:0]       coin_sel,
   output logic             busy,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] remaining,
   output logic [4:0]       inv_empty
);

   typedef enum logic [2:0] {IDLE, PICK, REQ, REL, DONE} state_t;

   localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_COUNT);

   state_t           state, state_nxt;
   logic [AMT_W-1:0] rem, rem_nxt;
   logic [CNT_W-1:0] cnt     [5];
   logic [CNT_W-1:0] cnt_nxt [5];
   logic             req_nxt;
   logic [4:0]       sel_nxt;
   logic             done_nxt;
   logic             short_nxt;
   logic [AMT_W-1:0] remaining_nxt;
   logic [4:0]       pick;

   // Face value of a one-hot coin select.
   function automatic logic [AMT_W-1:0] coin_value(input logic [4:0] sel);
      case (sel)
         5'b00001: coin_value = AMT_W'(5);
         5'b00010: coin_value = AMT_W'(10);
         5'b00100: coin_value = AMT_W'(25);
         5'b01000: coin_value = AMT_W'(50);
         5'b10000: coin_value = AMT_W'(100);
         default:  coin_value = '0;
      endcase
   endfunction

   // Largest coin in stock that does not exceed the remaining amount;
   // zero when no coin fits. Never selecting v > r keeps rem from underflowing.
   function automatic logic [4:0] pick_coin(input logic [AMT_W-1:0] r,
                                            input logic [4:0]       avail);
      if (avail[4] && r >= AMT_W'(100))      pick_coin = 5'b10000;
      else if (avail[3] && r >= AMT_W'(50))  pick_coin = 5'b01000;
      else if (avail[2] && r >= AMT_W'(25))  pick_coin = 5'b00100;
      else if (avail[1] && r >= AMT_W'(10))  pick_coin = 5'b00010;
      else if (avail[0] && r >= AMT_W'(5))   pick_coin = 5'b00001;
      else                                   pick_coin = 5'b00000;
   endfunction

   always_comb begin
      for (int i = 0; i < 5; i++) inv_empty[i] = (cnt[i] == '0);
   end

   assign busy = (state != IDLE);
   assign pick = pick_coin(rem, ~inv_empty);

   always_comb begin
      state_nxt     = state;
      rem_nxt       = rem;
      cnt_nxt       = cnt;
      req_nxt       = coin_req;
      sel_nxt       = coin_sel;
      done_nxt      = 1'b0;
      short_nxt     = short;
      remaining_nxt = remaining;
      case (state)
         IDLE: begin
            // start wins over refill; a simultaneous refill is dropped.
            if (start) begin
               rem_nxt       = amount;
               short_nxt     = 1'b0;
               remaining_nxt = '0;
               state_nxt     = PICK;
            end else if (refill) begin
               for (int i = 0; i < 5; i++) cnt_nxt[i] = INIT_CNT;
            end
         end
         PICK: begin
            if (pick != 5'b00000) begin
               sel_nxt   = pick;
               req_nxt   = 1'b1;
               state_nxt = REQ;
            end else begin
               // Result is registered here so it is valid in the done cycle.
               done_nxt      = 1'b1;
               remaining_nxt = rem;
               short_nxt     = (rem != '0);
               state_nxt     = DONE;
            end
         end
         REQ: begin
            if (coin_ack) begin
               for (int i = 0; i < 5; i++)
                  if (coin_sel[i]) cnt_nxt[i] = cnt[i] - 1'b1;
               rem_nxt   = rem - coin_value(coin_sel);
               req_nxt   = 1'b0;
               sel_nxt   = 5'b00000;
               state_nxt = REL;
            end
         end
         REL: begin
            // Wait for the mechanism to release ack so one ack = one coin.
            if (!coin_ack) state_nxt = PICK;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         rem       <= '0;
         coin_req  <= 1'b0;
         coin_sel  <= 5'b00000;
         done      <= 1'b0;
         short     <= 1'b0;
         remaining <= '0;
         for (int i = 0; i < 5; i++) cnt[i] <= INIT_CNT;
      end else begin
         state     <= state_nxt;
         rem       <= rem_nxt;
         coin_req  <= req_nxt;
         coin_sel  <= sel_nxt;
         done      <= done_nxt;
         short     <= short_nxt;
         remaining <= remaining_nxt;
         for (int i = 0; i < 5; i++) cnt[i] <= cnt_nxt[i];
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed testbench for change_dispenser. Instance dut0 uses the default
// inventory of 8 coins per denomination, dut1 uses INIT_COUNT=1.
module tb_change_dispenser;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] start, refill, coin_ack;
   logic [1:0][7:0] amount;

   logic       req0, busy0, done0, shrt0;
   logic [4:0] sel0, emp0;
   logic [7:0] rem0;
   logic       req1, busy1, done1, shrt1;
   logic [4:0] sel1, emp1;
   logic [7:0] rem1;

   int n_chk  = 0;
   int n_fail = 0;

   // Results of the most recent pay() call.
   logic [63:0] sig;
   int          ncoin;
   int          lat;
   logic [7:0]  o_rem;
   logic        o_short;

   always #5 clock = ~clock;

   change_dispenser #(.AMT_W(8), .CNT_W(4), .INIT_COUNT(8)) dut0 (
      .clock(clock), .reset(reset), .start(start[0]), .amount(amount[0]),
      .refill(refill[0]), .coin_ack(coin_ack[0]), .coin_req(req0),
      .coin_sel(sel0), .busy(busy0), .done(done0), .short(shrt0),
      .remaining(rem0), .inv_empty(emp0)
   );

   change_dispenser #(.AMT_W(8), .CNT_W(4), .INIT_COUNT(1)) dut1 (
      .clock(clock), .reset(reset), .start(start[1]), .amount(amount[1]),
      .refill(refill[1]), .coin_ack(coin_ack[1]), .coin_req(req1),
      .coin_sel(sel1), .busy(busy1), .done(done1), .short(shrt1),
      .remaining(rem1), .inv_empty(emp1)
   );

   function automatic logic get_req(input int d);
      return (d != 0) ? req1 : req0;
   endfunction
   function automatic logic get_busy(input int d);
      return (d != 0) ? busy1 : busy0;
   endfunction
   function automatic logic get_done(input int d);
      return (d != 0) ? done1 : done0;
   endfunction
   function automatic logic get_short(input int d);
      return (d != 0) ? shrt1 : shrt0;
   endfunction
   function automatic logic [4:0] get_sel(input int d);
      return (d != 0) ? sel1 : sel0;
   endfunction
   function automatic logic [7:0] get_rem(input int d);
      return (d != 0) ? rem1 : rem0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Run one payout on instance d. dly = cycles coin_req is left waiting
   // before ack rises, alen = cycles ack stays high. poke re-asserts start
   // (with a different amount) while the payout is busy.
   task automatic pay(input int d, input logic [7:0] amt, input int dly,
                      input int alen, input bit poke);
      int         waited;
      bit         fin;
      logic [4:0] s;
      sig = '0; ncoin = 0; lat = -1; fin = 0;
      @(negedge clock); start[d] = 1'b1; amount[d] = amt;
      @(negedge clock); start[d] = 1'b0;
      chk("busy_after_start", get_busy(d), 1);
      if (poke) begin start[d] = 1'b1; amount[d] = 8'd50; end
      for (int c = 0; c < 12 && !fin; c++) begin
         waited = 0;
         while (!get_req(d) && !get_done(d) && waited < 40) begin
            @(negedge clock);
            start[d] = 1'b0;
            waited++;
         end
         if (c == 0) lat = waited;
         if (waited >= 40) begin
            chk("timeout", 1, 0);
            fin = 1;
         end else if (get_done(d)) begin
            fin = 1;
         end else begin
            s = get_sel(d);
            sig = {sig[58:0], s};
            ncoin++;
            for (int i = 0; i < dly; i++) begin
               @(negedge clock);
               chk("req_held", get_req(d), 1);
               chk("sel_held", get_sel(d), s);
            end
            coin_ack[d] = 1'b1;
            for (int i = 0; i < alen; i++) begin
               @(negedge clock);
               chk("req_drop", get_req(d), 0);
            end
            coin_ack[d] = 1'b0;
         end
      end
      o_rem   = get_rem(d);
      o_short = get_short(d);
      @(negedge clock);
      chk("done_single", get_done(d), 0);
      chk("idle_after_done", get_busy(d), 0);
   endtask

   task automatic do_refill(input int d);
      @(negedge clock); refill[d] = 1'b1;
      @(negedge clock); refill[d] = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      start = '0; refill = '0; coin_ack = '0; amount = '0;
      #12;
      chk("rst_req", req0, 0);
      chk("rst_sel", sel0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_short", shrt0, 0);
      chk("rst_rem", rem0, 0);
      chk("rst_empty0", emp0, 5'b00000);
      chk("rst_empty1", emp1, 5'b00000);
      @(negedge clock); reset = 1'b1;

      // 185 = 100+50+25+10, with a start poked in while busy
      pay(0, 8'd185, 0, 1, 1);
      chk("p185_coins", sig, {5'b10000, 5'b01000, 5'b00100, 5'b00010});
      chk("p185_lat", lat, 1);
      chk("p185_rem", o_rem, 0);
      chk("p185_short", o_short, 0);
      chk("p185_cnt4", dut0.cnt[4], 7);
      chk("p185_cnt1", dut0.cnt[1], 7);
      chk("p185_cnt0", dut0.cnt[0], 8);
      chk("p185_empty", emp0, 5'b00000);
      repeat (3) @(negedge clock);
      chk("poke_ignored_req", req0, 0);
      chk("poke_ignored_busy", busy0, 0);

      // 7 = one 5 coin, 2 unpaid
      pay(0, 8'd7, 0, 1, 0);
      chk("p7_coins", sig, {5'b00001});
      chk("p7_rem", o_rem, 2);
      chk("p7_short", o_short, 1);

      // zero amount: done two edges after start, nothing ejected
      pay(0, 8'd0, 0, 1, 0);
      chk("p0_ncoin", ncoin, 0);
      chk("p0_lat", lat, 1);
      chk("p0_short", o_short, 0);
      chk("p0_rem", o_rem, 0);

      // 200 five times from a full inventory: 100s run out after 4 runs
      do_refill(0);
      chk("refill_cnt0", dut0.cnt[0], 8);
      for (int r = 0; r < 4; r++) begin
         pay(0, 8'd200, 0, 1, 0);
         chk("p200_coins", sig, {5'b10000, 5'b10000});
      end
      chk("p200_empty4", emp0, 5'b10000);
      pay(0, 8'd200, 0, 1, 0);
      chk("p200_run5", sig, {5'b01000, 5'b01000, 5'b01000, 5'b01000});
      chk("p200_run5_rem", o_rem, 0);
      chk("p200_run5_short", o_short, 0);
      chk("p200_cnt3", dut0.cnt[3], 4);

      // slow mechanism: req held 4 cycles, ack held 5 cycles
      do_refill(0);
      pay(0, 8'd35, 4, 5, 0);
      chk("slow_coins", sig, {5'b00100, 5'b00010});
      chk("slow_cnt2", dut0.cnt[2], 7);
      chk("slow_cnt1", dut0.cnt[1], 7);
      chk("slow_rem", o_rem, 0);

      // single-coin inventory instance
      pay(1, 8'd195, 0, 1, 0);
      chk("one_coins", sig, {5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001});
      chk("one_rem", o_rem, 5);
      chk("one_short", o_short, 1);
      chk("one_empty", emp1, 5'b11111);
      do_refill(1);
      chk("one_refill_empty", emp1, 5'b00000);

      // reset asserted mid-handshake
      @(negedge clock); start[0] = 1'b1; amount[0] = 8'd25;
      @(negedge clock); start[0] = 1'b0;
      @(negedge clock);
      chk("mid_req", req0, 1);
      chk("mid_sel", sel0, 5'b00100);
      #3 reset = 1'b0;
      #1;
      chk("async_req", req0, 0);
      chk("async_busy", busy0, 0);
      chk("async_cnt2", dut0.cnt[2], 8);
      @(negedge clock); reset = 1'b1;
      pay(0, 8'd185, 0, 1, 0);
      chk("post_rst_coins", sig, {5'b10000, 5'b01000, 5'b00100, 5'b00010});
      chk("post_rst_rem", o_rem, 0);
      chk("post_rst_cnt2", dut0.cnt[2], 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Returns change coin by coin at the output end of the vending machine's coin path, mirroring the five-denomination coin acceptor (R$0,05 / 0,10 / 0,25 / 0,50 / 1,00). The vending controller hands over a change amount in centavos. The block decomposes it greedily against its own per-denomination coin inventory and drives a payout mechanism one coin at a time through a req/ack handshake. At the end it reports any amount it could not pay.

## Interface
- AMT_W, 8: width of amount/remaining, in centavos.
- CNT_W, 4: width of each inventory counter.
- INIT_COUNT, 8: coins per denomination after reset or refill. Must fit in CNT_W.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request payout of `amount`. Sampled only in IDLE.
- amount  in  AMT_W  change to pay, in centavos.
- refill  in  1  reload all counters to INIT_COUNT. Honoured only in IDLE.
- coin_ack  in  1  payout mechanism has ejected the requested coin (level).
- coin_req  out  1  request ejection of the coin on coin_sel.
- coin_sel  out  5  one-hot coin select: bit0=5, bit1=10, bit2=25, bit3=50, bit4=100.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse at end of a payout.
- short  out  1  with done: unpaid amount nonzero. Held until next accepted start.
- remaining  out  AMT_W  unpaid amount. Held until next accepted start.
- inv_empty  out  5  per-denomination counter == 0, same bit order as coin_sel.

## Operation
- States: IDLE, PICK, REQ, REL, DONE.
- IDLE:
  - start=1: latch amount into rem, clear short/remaining, go PICK.
  - Else if refill=1: all counters ← INIT_COUNT.
  - start has priority over refill in the same cycle. The refill is dropped.
- PICK: choose the largest denomination v with v ≤ rem and count>0.
  - If one exists: register coin_sel=its bit, coin_req=1, go REQ.
  - If none: go DONE.
- REQ: coin_req and coin_sel stay stable until coin_ack=1 is sampled. On that edge:
  - that counter −1
  - rem ← rem − v
  - coin_req ← 0, coin_sel ← 0
  - go REL
- REL: wait for coin_ack=0, then go PICK.
- DONE: done=1, remaining ← rem, short ← (rem≠0), go IDLE.
- Greedy without backtracking is the decided algorithm. Inventory-induced shortfall is reported through short; no alternate coin combination is searched.
- rem never underflows, because a coin is selected only if v ≤ rem.
- A non-multiple-of-5 amount leaves a residue in remaining, with short=1.
- start, refill and coin_ack outside their stated states are ignored.
- coin_ack=1 while in PICK or IDLE has no effect.
- Reset (async, any state):
  - state IDLE, counters ← INIT_COUNT, rem 0
  - coin_req 0, coin_sel 0, busy 0, done 0, short 0, remaining 0
  - inv_empty 0 when INIT_COUNT>0
  - A coin mid-handshake is abandoned and not counted.

## Timing
- All outputs are registered. inv_empty and busy are decoded from registers with no input-to-output combinational path.
- start sampled at edge k: busy=1 after k.
- First coin_req=1 after edge k+1.
- coin_ack=1 sampled at edge m: coin_req=0 after m, and the counter is updated after m.
- coin_ack=0 sampled at edge n: the next coin_req is asserted after edge n+1.
  - With a one-cycle ack pulse (ack high at m, low at m+1), consecutive coin_req windows are separated by 2 low cycles.
- PICK finding no coin at edge p: done=1 for the single cycle after p, with remaining/short valid in that same cycle. busy=0 after p+1.
- amount=0: done in the cycle after edge k+1, short=0.
- No start is accepted during the done cycle. start is accepted again from the cycle after it.

## Test plan
- Reset, then amount=185 with 1-cycle ack responder: coins 100,50,25,10 in that order, each coin_sel stable during its coin_req, done once, short=0, remaining=0. Counts bit4..bit1 become 7, and inv_empty stays 0.
- amount=0: done exactly 2 edges after start, no coin_req, short=0. start asserted while busy in a prior run is ignored (no second payout).
- INIT_COUNT=1 instance, amount=195: coins 100,50,25,10,5, then remaining=5, short=1, inv_empty=5'b11111. refill in IDLE clears inv_empty to 0.
- amount=7: one 5 coin, remaining=2, short=1. amount=200 with default inventory, run 5 times: fifth run pays 100? no, the 100s are exhausted after 4 runs (8 coins), so the fifth run pays 50×4. inv_empty[4]=1.
- ack stretched to 5 cycles: coin_req and coin_sel held, a single decrement per coin. ack held high 3 cycles after coin_req drops: no extra coin until ack falls.
- reset pulsed low during REQ: coin_req=0 and busy=0 immediately (before the next clock edge), counters back to INIT_COUNT. A new start afterwards completes normally.
